fetch: RTL and testbench

Instruction fetch stage of the 16-bit pipelined CPU; it produces the instruction-memory read address each cycle. It presents the decode stage with the PC and valid/bubble flag that match the instruction word returned by memory. It honours the decode stage's `stall`, the execute stage's redirect (`flush` plus target) and the global `halt` freeze. It sits between the synchronous instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_perf_counters.sv | 29 ++
 rtl/fetch.sv | 80 ++++++++
 tb/tb_fetch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings,
// instruction width and the default reset PC.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PERF_W  = 32;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic {
    FETCH_FILL = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_perf_counters.sv
// Three wrapping 32-bit event counters for the fetch stage; reset clears,
// halt freezes. Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              inc_fetched,
  input  logic              inc_stalls,
  input  logic              inc_flushes,
  output logic [PERF_W-1:0] fetched,
  output logic [PERF_W-1:0] stalls,
  output logic [PERF_W-1:0] flushes
);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched <= '0;
      stalls  <= '0;
      flushes <= '0;
    end else if (!halt) begin
      if (inc_fetched) fetched <= fetched + 32'd1;
      if (inc_stalls)  stalls  <= stalls  + 32'd1;
      if (inc_flushes) flushes <= flushes + 32'd1;
    end
  end

endmodule : fetch_perf_counters

// File: rtl/fetch.sv
// Instruction fetch stage: drives the instruction-memory address and tells
// decode which PC/bubble matches the returned word. Optional performance
// counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] branch_tgt,
  output logic [INSTR_W-1:0] mem_addr,
  output logic [INSTR_W-1:0] pc_out,
  output logic               bubble_out,
  output logic [PERF_W-1:0]  perf_fetched,
  output logic [PERF_W-1:0]  perf_stalls,
  output logic [PERF_W-1:0]  perf_flushes
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] fetch_pc;

  // Priority: reset > halt > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pc_out     <= '0;
      bubble_out <= 1'b1;
      state      <= FETCH_FILL;
    end else if (!halt) begin
      if (flush) begin
        fetch_pc   <= branch_tgt;
        bubble_out <= 1'b1;
        state      <= FETCH_FILL;
      end else if (!stall) begin
        pc_out     <= fetch_pc;
        fetch_pc   <= fetch_pc + 16'd1;
        bubble_out <= 1'b0;
        state      <= FETCH_RUN;
      end
    end
  end

  assign mem_addr = fetch_pc;

  // bubble_out is kept as its own flop; it must always agree with the state.
  a_bubble_matches_state: assert property (
    @(posedge clk) disable iff (reset) bubble_out == (state == FETCH_FILL)
  );

`ifdef FETCH_PERF_CNT_EN
  logic adv_en;
  logic stall_en;
  logic flush_en;

  assign flush_en = flush;
  assign stall_en = stall && !flush;
  assign adv_en   = !stall && !flush;

  fetch_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .inc_fetched (adv_en),
    .inc_stalls  (stall_en),
    .inc_flushes (flush_en),
    .fetched     (perf_fetched),
    .stalls      (perf_stalls),
    .flushes     (perf_flushes)
  );
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule : fetch

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a directed vector table from the test plan,
// a few multi-cycle sequences, then randomized traffic against a reference model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] branch_tgt = 16'h0000;
  logic [15:0] mem_addr;
  logic [15:0] pc_out;
  logic        bubble_out;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] RST_PC = 16'h0010;

  fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .stall        (stall),
    .flush        (flush),
    .branch_tgt   (branch_tgt),
    .mem_addr     (mem_addr),
    .pc_out       (pc_out),
    .bubble_out   (bubble_out),
    .perf_fetched (perf_fetched),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
  );

  always #5 clk = ~clk;

  // Reference model: the fetch stream viewed as "next address to request",
  // "address whose word decode sees now" and "is that word real".
  logic [15:0] m_next;
  logic [15:0] m_seen;
  logic        m_bub;
  logic [31:0] m_fetched, m_stalls, m_flushes;

  task automatic model_update();
    if (reset) begin
      m_next = RST_PC; m_seen = 16'h0000; m_bub = 1'b1;
      m_fetched = 0; m_stalls = 0; m_flushes = 0;
    end else if (halt) begin
      // frozen
    end else if (flush) begin
      m_next = branch_tgt; m_bub = 1'b1; m_flushes = m_flushes + 1;
    end else if (stall) begin
      m_stalls = m_stalls + 1;
    end else begin
      m_seen = m_next;
      m_next = 16'((32'(m_next) + 1) % 65536);
      m_bub = 1'b0;
      m_fetched = m_fetched + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic chk_model();
    chk("model_mem_addr", 32'(mem_addr), 32'(m_next));
    chk("model_pc_out", 32'(pc_out), 32'(m_seen));
    chk("model_bubble_out", 32'(bubble_out), 32'(m_bub));
    chk("perf_fetched", perf_fetched, cnt_exp(m_fetched));
    chk("perf_stalls", perf_stalls, cnt_exp(m_stalls));
    chk("perf_flushes", perf_flushes, cnt_exp(m_flushes));
  endtask

  // Drive one cycle's inputs, clock, then sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic h, input logic f, input logic s,
                       input logic [15:0] t);
    reset = r; halt = h; flush = f; stall = s; branch_tgt = t;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic        r, h, f, s;
    logic [15:0] tgt;
    logic [15:0] mem;
    logic [15:0] pc;
    logic        bub;
  } vec_t;

  vec_t tbl[22];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0011, 16'h0010, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0012, 16'h0011, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0013, 16'h0012, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0013, 16'h0012, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0013, 16'h0012, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0013, 16'h0012, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0014, 16'h0013, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0013, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0101, 16'h0100, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0100, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 16'h0040, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0040, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0001, 16'h0000, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h5678, 16'h0001, 16'h0000, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h9ABC, 16'h0001, 16'h0000, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hDEF0, 16'h0001, 16'h0000, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h0000, 1'b1};

    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].s, tbl[i].tgt);
      chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].mem));
      chk($sformatf("tbl%0d_pc_out", i), 32'(pc_out), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_bubble_out", i), 32'(bubble_out), 32'(tbl[i].bub));
      chk_model();
      if (i == 9) chk("flush_count_after_redirect", perf_flushes, cnt_exp(32'd1));
    end
    chk("reset_perf_fetched", perf_fetched, 32'd0);
    chk("reset_perf_stalls", perf_stalls, 32'd0);
    chk("reset_perf_flushes", perf_flushes, 32'd0);

    // Reset immediately after a flush: the pending target must be discarded.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0ABC);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("reset_mid_redirect_mem", 32'(mem_addr), 32'(RST_PC));
    chk("reset_mid_redirect_pc", 32'(pc_out), 32'h0);
    chk("reset_mid_redirect_bub", 32'(bubble_out), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("after_reset_first_pc", 32'(pc_out), 32'(RST_PC));
    chk("after_reset_first_bub", 32'(bubble_out), 32'h0);

    // Halt release resumes without an extra bubble.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("halt_release_pc", 32'(pc_out), 32'(RST_PC) + 32'd1);
    chk("halt_release_bub", 32'(bubble_out), 32'h0);
    chk_model();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r, h, f, s;
      logic [15:0] t;
      r = ($urandom_range(63) == 0);
      h = ($urandom_range(7) == 0);
      f = ($urandom_range(7) == 0);
      s = ($urandom_range(3) == 0);
      t = ($urandom_range(7) == 0) ? 16'hFFFE : 16'($urandom);
      cycle(r, h, f, s, t);
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch
